// File: rtl/data_reg_queue.sv
// data_reg_queue
// --------------
// DEPTH-entry, WIDTH-bit first-word-fall-through queue between the memory
// data bus (push side) and the S8SP datapath (pop side). It replaces the
// original single 8-bit data register.
//
// Optional feature: define DRQ_LEVEL_EN to add the level / almost_full ports.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high; clears pointers, count, storage, flags
//   load_dr      push request (data_on_dr written when accepted)
//   data_on_dr   push data
//   pop_dr       pop request (head consumed when accepted)
//   flush        synchronous clear of pointers/count; storage and flags kept
//   clr_err      clears sticky overflow/underflow
//   dr_on_data   head entry, 0 when empty
//   dr_valid     queue non-empty
//   full         queue holds DEPTH entries
//   overflow     sticky: push while full without an accepted pop
//   underflow    sticky: pop while empty
//   level        (DRQ_LEVEL_EN) current occupancy
//   almost_full  (DRQ_LEVEL_EN) occupancy >= DEPTH-1

module data_reg_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_dr,
    input  logic [WIDTH-1:0] data_on_dr,
    input  logic             pop_dr,
    input  logic             flush,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dr_on_data,
    output logic             dr_valid,
    output logic             full,
    output logic             overflow,
`ifdef DRQ_LEVEL_EN
    output logic             underflow,
    output logic [AW:0]      level,
    output logic             almost_full
`else
    output logic             underflow
`endif
);

    localparam logic [AW:0] L_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0] L_DEPTHM1 = (AW+1)'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_valid;
    logic             w_full;
    logic             w_pop_acc;
    logic             w_push_acc;
    logic             w_ovf_set;
    logic             w_unf_set;

    always_comb begin
        w_valid    = (r_count != '0);
        w_full     = (r_count == L_DEPTH);
        w_pop_acc  = pop_dr & w_valid;
        // A pop in the same cycle frees the head slot, so a full queue can
        // still accept the push.
        w_push_acc = load_dr & (~w_full | w_pop_acc);
        w_ovf_set  = load_dr & w_full & ~w_pop_acc;
        w_unf_set  = pop_dr & ~w_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            // Requests are dropped silently and error flags are frozen.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_mem[r_wr_ptr] <= data_on_dr;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Set event takes priority over clr_err.
            if (w_ovf_set)    r_overflow <= 1'b1;
            else if (clr_err) r_overflow <= 1'b0;
            if (w_unf_set)    r_underflow <= 1'b1;
            else if (clr_err) r_underflow <= 1'b0;
        end
    end

    always_comb begin
        dr_valid   = w_valid;
        full       = w_full;
        overflow   = r_overflow;
        underflow  = r_underflow;
        dr_on_data = w_valid ? r_mem[r_rd_ptr] : '0;
    end

`ifdef DRQ_LEVEL_EN
    always_comb begin
        level       = r_count;
        almost_full = (r_count >= L_DEPTHM1);
    end
`endif

endmodule

// File: tb/tb_data_reg_queue.sv
// Scoreboard bench for data_reg_queue (WIDTH=8, DEPTH=4). Stimulus pushes the
// hand-computed sequence of values expected to leave the queue; a monitor
// compares the head whenever an accepted pop is presented.
module tb_data_reg_queue;

    logic       clk;
    logic       reset;
    logic       load_dr;
    logic [7:0] data_on_dr;
    logic       pop_dr;
    logic       flush;
    logic       clr_err;
    logic [7:0] dr_on_data;
    logic       dr_valid;
    logic       full;
    logic       overflow;
    logic       underflow;
`ifdef DRQ_LEVEL_EN
    logic [2:0] level;
    logic       almost_full;
`endif

    int nvec;
    int nerr;
    logic [7:0] exp_q[$];

    data_reg_queue #(
        .WIDTH(8),
        .DEPTH(4),
        .AW(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_dr    (load_dr),
        .data_on_dr (data_on_dr),
        .pop_dr     (pop_dr),
        .flush      (flush),
        .clr_err    (clr_err),
        .dr_on_data (dr_on_data),
        .dr_valid   (dr_valid),
        .full       (full),
        .overflow   (overflow),
`ifdef DRQ_LEVEL_EN
        .underflow  (underflow),
        .level      (level),
        .almost_full(almost_full)
`else
        .underflow  (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitor: an accepted pop is visible at the falling edge before it commits.
    always @(negedge clk) begin
        if (!reset && !flush && pop_dr && dr_valid) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL pop_data: got %02h, expected no data (scoreboard empty)", dr_on_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dr_on_data !== e) begin
                    nerr++;
                    $display("FAIL pop_data: got %02h, expected %02h", dr_on_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_level(input string name, input int exp);
`ifdef DRQ_LEVEL_EN
        chk(name, 32'(level), 32'(exp));
`endif
    endtask

    // Drive one cycle of inputs, then return just after the rising edge.
    task automatic step(input logic ld, input logic [7:0] d, input logic pp,
                        input logic fl, input logic ce, input logic rs);
        load_dr    = ld;
        data_on_dr = d;
        pop_dr     = pp;
        flush      = fl;
        clr_err    = ce;
        reset      = rs;
        @(posedge clk);
        #1;
        load_dr = 1'b0; pop_dr = 1'b0; flush = 1'b0; clr_err = 1'b0; reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        load_dr = 0; data_on_dr = 0; pop_dr = 0; flush = 0; clr_err = 0; reset = 1;
        @(posedge clk); #1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", 32'(dr_valid), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_data", 32'(dr_on_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);
        chk_level("rst_level", 0);

        // Three consecutive pushes, head falls through after the first.
        exp_q.push_back(8'h11); push(8'h11);
        chk("t1_head", 32'(dr_on_data), 32'h11);
        chk("t1_valid", 32'(dr_valid), 1);
        exp_q.push_back(8'h22); push(8'h22);
        exp_q.push_back(8'h33); push(8'h33);
        chk("t1_full", 32'(full), 0);
        chk("t1_head3", 32'(dr_on_data), 32'h11);
        chk_level("t1_level", 3);
        repeat (3) pop();
        chk("t1_empty", 32'(dr_valid), 0);

        // Fill, overflow push, drain in order.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            push(8'hA0 + 8'(i));
        end
        chk("t2_full", 32'(full), 1);
        push(8'hFF);
        chk("t2_ovf", 32'(overflow), 1);
        chk("t2_full2", 32'(full), 1);
        repeat (4) pop();
        chk("t2_empty", 32'(dr_valid), 0);
        chk("t2_data0", 32'(dr_on_data), 0);
        clr();
        chk("t2_ovf_clr", 32'(overflow), 0);

        // Full queue, push and pop together.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'hB0 + 8'(i));
            push(8'hB0 + 8'(i));
        end
        exp_q.push_back(8'h55);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_head", 32'(dr_on_data), 32'hB1);
        chk("t3_full", 32'(full), 1);
        chk("t3_ovf", 32'(overflow), 0);
        chk_level("t3_level", 4);
        repeat (4) pop();
        chk("t3_empty", 32'(dr_valid), 0);

        // Ten items at occupancy <= 2, pointers wrap twice.
        exp_q.push_back(8'h01); push(8'h01);
        for (int i = 2; i <= 10; i++) begin
            exp_q.push_back(8'(i));
            step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        pop();
        chk("t4_empty", 32'(dr_valid), 0);
        pop();
        chk("t4_unf", 32'(underflow), 1);
        clr();
        chk("t4_unf_clr", 32'(underflow), 0);

        // Empty queue, push and pop together: push wins, underflow flags.
        exp_q.push_back(8'h5A);
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4b_head", 32'(dr_on_data), 32'h5A);
        chk("t4b_unf", 32'(underflow), 1);
        chk_level("t4b_level", 1);
        pop();
        // Clear on the same cycle as a fresh underflow event: set wins.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4b_set_wins", 32'(underflow), 1);
        // Flush with 3 entries and a push; flags must survive.
        push(8'hC1); push(8'hC2); push(8'hC3);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_valid", 32'(dr_valid), 0);
        chk("t5_data", 32'(dr_on_data), 0);
        chk("t5_unf_kept", 32'(underflow), 1);
        chk("t5_ovf_kept", 32'(overflow), 0);
        chk_level("t5_level", 0);
        exp_q.push_back(8'h88); push(8'h88);
        chk("t5_head", 32'(dr_on_data), 32'h88);
        pop();
        clr();
        chk("t5_clr", 32'(underflow), 0);

        // Mid-operation reset with 2 entries and overflow set.
        for (int i = 0; i < 4; i++) begin
            if (i < 2) exp_q.push_back(8'hE0 + 8'(i));
            push(8'hE0 + 8'(i));
        end
        push(8'hFF);
        pop(); pop();
        chk("t6_ovf_pre", 32'(overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_valid", 32'(dr_valid), 0);
        chk("t6_data", 32'(dr_on_data), 0);
        chk("t6_full", 32'(full), 0);
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_unf", 32'(underflow), 0);
        chk_level("t6_level", 0);
        exp_q.push_back(8'h3C); push(8'h3C);
        chk("t6_head", 32'(dr_on_data), 32'h3C);
        pop();
        chk("t6_empty", 32'(dr_valid), 0);

        @(posedge clk); #1;
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
